// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and helpers for the memory-access stage:
//                access-size and FSM-state enums, byte-enable mask and
//                access-size decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Access size as carried on memSize
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } mem_size_t;

    // Memory-stage controller states
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_HOLD = 2'd3
    } mem_state_t;

    // Number of bytes moved by an access of the given size
    function automatic logic [3:0] size_bytes(input mem_size_t size);
        logic [3:0] bytes;
        case (size)
            SIZE_B:  bytes = 4'd1;
            SIZE_H:  bytes = 4'd2;
            SIZE_W:  bytes = 4'd4;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

    // Byte-lane enables of an access: a run of size_bytes ones starting at
    // lane 'offset' of the 8-lane doubleword
    function automatic logic [7:0] be_mask(input mem_size_t size,
                                           input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            SIZE_W:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data aligner. Moves the addressed bytes
//                of a read doubleword down to lane 0 and sign- or
//                zero-extends them to the full datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] rdata_i,
    input  logic [2:0]   offset_i,
    input  mem_size_t    size_i,
    input  logic         unsigned_i,
    output logic [N-1:0] data_o
);

    logic [N-1:0] w_shifted;
    logic [N-1:0] w_mask;
    logic         w_sign;

    // Lane shift, keep only the accessed bytes, then fill the upper bits
    always_comb begin
        w_shifted = rdata_i >> {offset_i, 3'b000};
        w_mask    = '0;
        w_sign    = 1'b0;
        case (size_i)
            SIZE_B: begin
                w_mask = N'(64'h0000_0000_0000_00FF);
                w_sign = w_shifted[7];
            end
            SIZE_H: begin
                w_mask = N'(64'h0000_0000_0000_FFFF);
                w_sign = w_shifted[15];
            end
            SIZE_W: begin
                w_mask = N'(64'h0000_0000_FFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: begin
                // A doubleword already fills the datapath; nothing to extend
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
        data_o = (w_shifted & w_mask) |
                 ((w_sign & ~unsigned_i) ? ~w_mask : '0);
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage. Issues aligned loads/stores
//                over a req/gnt/rvalid data-memory port, aligns and extends
//                load data, flags misaligned accesses, stalls upstream while
//                an access is in flight and drives the MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           regEn,
    input  logic           validIn,
    input  logic [N-1:0]   ALUres,
    input  logic [N-1:0]   Bout,
    input  logic           memRead,
    input  logic           memWrite,
    input  logic [1:0]     memSize,
    input  logic           memUnsigned,
    input  logic [4:0]     rdIn,
    input  logic           regWriteIn,
    output logic           dmemReq,
    output logic           dmemWe,
    output logic [N-1:0]   dmemAddr,
    output logic [N-1:0]   dmemWdata,
    output logic [N/8-1:0] dmemBe,
    input  logic           dmemGnt,
    input  logic           dmemRvalid,
    input  logic [N-1:0]   dmemRdata,
    output logic           stall,
    output logic           validOut,
    output logic [N-1:0]   resultOut,
    output logic [4:0]     rdOut,
    output logic           regWriteOut,
    output logic           misalign
);

    localparam logic [1:0] C_ST_IDLE = MS_IDLE;
    localparam logic [1:0] C_ST_REQ  = MS_REQ;
    localparam logic [1:0] C_ST_WAIT = MS_WAIT;
    localparam logic [1:0] C_ST_HOLD = MS_HOLD;

    // Controller state
    logic [1:0]     state_q, state_d;

    // Access captured at acceptance; the memory port is driven from these
    logic [N-1:0]   addr_q;
    logic [N-1:0]   wdata_q;
    logic [N/8-1:0] be_q;
    mem_size_t      size_q;
    logic           uns_q;
    logic           we_q;
    logic [4:0]     rd_q;
    logic           rw_q;

    // Result parked while the pipeline is frozen at completion
    logic [N-1:0]   buf_q;

    // MEM/WB register
    logic           valid_q, valid_d;
    logic [N-1:0]   res_q, res_d;
    logic [4:0]     rdo_q, rdo_d;
    logic           rwo_q, rwo_d;
    logic           mis_q, mis_d;

    // Decode of the incoming instruction
    logic [2:0]     w_offset;
    mem_size_t      w_size;
    logic           w_memop;
    logic           w_aligned;
    logic           w_idle;
    logic           w_accept;
    logic           w_misacc;
    logic           w_passthru;
    logic [7:0]     w_be_full;

    // Completion events of the in-flight access
    logic           w_in_req;
    logic           w_in_wait;
    logic           w_in_hold;
    logic           w_store_gnt;
    logic           w_load_rvalid;
    logic           w_finish;
    logic           w_complete;
    logic           w_park;
    logic [N-1:0]   w_ldata;
    logic [N-1:0]   w_done_res;

    assign w_offset   = ALUres[2:0];
    assign w_size     = mem_size_t'(memSize);
    assign w_memop    = memRead | memWrite;
    assign w_aligned  = (w_offset & 3'(size_bytes(w_size) - 4'd1)) == 3'd0;
    assign w_be_full  = be_mask(w_size, w_offset);

    assign w_idle     = (state_q == C_ST_IDLE);
    assign w_in_req   = (state_q == C_ST_REQ);
    assign w_in_wait  = (state_q == C_ST_WAIT);
    assign w_in_hold  = (state_q == C_ST_HOLD);

    // Instructions are only looked at in IDLE
    assign w_accept   = w_idle & regEn & validIn & w_memop & w_aligned;
    assign w_misacc   = w_idle & regEn & validIn & w_memop & ~w_aligned;
    assign w_passthru = w_idle & regEn & validIn & ~w_memop;

    // A store finishes on its grant, a load on its read data
    assign w_store_gnt   = w_in_req & dmemGnt & we_q;
    assign w_load_rvalid = w_in_wait & dmemRvalid;
    assign w_finish      = w_store_gnt | w_load_rvalid;
    // Finishing while frozen parks the result in the HOLD buffer instead
    assign w_park        = w_finish & ~regEn;
    assign w_complete    = regEn & (w_finish | w_in_hold);

    load_align #(
        .N (N)
    ) u_load_align (
        .rdata_i    (dmemRdata),
        .offset_i   (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (w_ldata)
    );

    // A store reports its effective address as the result
    assign w_done_res = w_in_hold ? buf_q : (we_q ? addr_q : w_ldata);

    // Memory port is only active in REQ; payload is held stable from latches
    assign dmemReq   = w_in_req;
    assign dmemWe    = w_in_req & we_q;
    assign dmemBe    = w_in_req ? be_q : '0;
    assign dmemAddr  = {addr_q[N-1:3], 3'b000};
    assign dmemWdata = wdata_q;

    // Hold upstream while an access is pending, released in the completion cycle
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            stall = (w_idle & validIn & w_memop & w_aligned) |
                    (w_in_req  & ~(w_store_gnt & regEn))    |
                    (w_in_wait & ~(dmemRvalid & regEn))     |
                    (w_in_hold & ~regEn);
        end
    end

    // Next-state logic of the access controller
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    state_d = C_ST_REQ;
                end
            end
            C_ST_REQ: begin
                if (dmemGnt) begin
                    if (!we_q) begin
                        state_d = C_ST_WAIT;
                    end else begin
                        state_d = regEn ? C_ST_IDLE : C_ST_HOLD;
                    end
                end
            end
            C_ST_WAIT: begin
                if (dmemRvalid) begin
                    state_d = regEn ? C_ST_IDLE : C_ST_HOLD;
                end
            end
            C_ST_HOLD: begin
                if (regEn) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    // Next value of the MEM/WB register; frozen whenever regEn is low
    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        rwo_d   = rwo_q;
        mis_d   = mis_q;
        if (regEn) begin
            valid_d = 1'b0;
            rwo_d   = 1'b0;
            mis_d   = 1'b0;
            if (w_passthru) begin
                valid_d = 1'b1;
                res_d   = ALUres;
                rdo_d   = rdIn;
                rwo_d   = regWriteIn;
            end else if (w_misacc) begin
                valid_d = 1'b1;
                res_d   = ALUres;
                rdo_d   = rdIn;
                mis_d   = 1'b1;
            end else if (w_complete) begin
                valid_d = 1'b1;
                res_d   = w_done_res;
                rdo_d   = rd_q;
                rwo_d   = rw_q & ~we_q;
            end
        end
    end

    // State and MEM/WB register update
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= C_ST_IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            rdo_q   <= 5'd0;
            rwo_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
            rwo_q   <= rwo_d;
            mis_q   <= mis_d;
        end
    end

    // Capture the access on acceptance and park a frozen completion
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            size_q  <= SIZE_B;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            buf_q   <= '0;
        end else begin
            if (w_accept) begin
                addr_q  <= ALUres;
                wdata_q <= Bout << {w_offset, 3'b000};
                be_q    <= w_be_full[N/8-1:0];
                size_q  <= w_size;
                uns_q   <= memUnsigned;
                we_q    <= memWrite;
                rd_q    <= rdIn;
                rw_q    <= regWriteIn;
            end
            if (w_park) begin
                buf_q <= w_done_res;
            end
        end
    end

    assign validOut    = valid_q;
    assign resultOut   = res_q;
    assign rdOut       = rdo_q;
    assign regWriteOut = rwo_q;
    assign misalign    = mis_q;

endmodule : mem_stage
`default_nettype wire
